// File: rtl/tlb_op_controller.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_controller
// Description : Write-back stage sequencer for TLBP / TLBR / TLBWI. Holds WB
//               (op_done is its ready-go) while it drives the shared TLB
//               search/read/write port and the CP0 update strobes in a fixed
//               REQ -> WAIT -> DONE order.
//               Optional feature macro: TLB_REFETCH_EN (refetch request from
//               op_pc + 4 after TLBR/TLBWI).
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_controller #(
  parameter int TLB_INDEX_WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [1:0]                 op_kind,
  input  logic [31:0]                op_pc,
  input  logic                       abort,
  input  logic [31:0]                cp0_entryhi,
  input  logic [TLB_INDEX_WIDTH-1:0] cp0_index,
  output logic                       tlb_search_valid,
  output logic [18:0]                tlb_search_vpn2,
  output logic [7:0]                 tlb_search_asid,
  input  logic                       tlb_search_hit,
  input  logic [TLB_INDEX_WIDTH-1:0] tlb_search_index,
  output logic                       tlb_read_valid,
  output logic [TLB_INDEX_WIDTH-1:0] tlb_read_index,
  output logic                       tlb_write_valid,
  output logic [TLB_INDEX_WIDTH-1:0] tlb_write_index,
  output logic                       cp0_probe_we,
  output logic [31:0]                cp0_probe_data,
  output logic                       cp0_tlbr_we,
  output logic                       op_done,
  output logic                       busy,
  output logic                       refetch_valid,
  output logic [31:0]                refetch_pc
);

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_TLBP  = 2'b01;
  localparam logic [1:0] KIND_TLBR  = 2'b10;
  localparam logic [1:0] KIND_TLBWI = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                     state_q;
  logic [1:0]                 kind_q;
  logic [18:0]                vpn2_q;
  logic [7:0]                 asid_q;
  logic [TLB_INDEX_WIDTH-1:0] index_q;

  logic search_valid_q;
  logic read_valid_q;
  logic write_valid_q;
  logic probe_we_q;
  logic tlbr_we_q;
  logic op_done_q;

`ifdef TLB_REFETCH_EN
  logic [31:0] pc_q;
  logic        refetch_valid_q;
  logic [31:0] refetch_pc_q;
`endif

  // Sequencer: state, operand latches and one-cycle strobes, all registered so
  // every strobe is a clean decode of the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      kind_q         <= KIND_NONE;
      vpn2_q         <= '0;
      asid_q         <= '0;
      index_q        <= '0;
      search_valid_q <= 1'b0;
      read_valid_q   <= 1'b0;
      write_valid_q  <= 1'b0;
      probe_we_q     <= 1'b0;
      tlbr_we_q      <= 1'b0;
      op_done_q      <= 1'b0;
`ifdef TLB_REFETCH_EN
      pc_q            <= '0;
      refetch_valid_q <= 1'b0;
      refetch_pc_q    <= '0;
`endif
    end else begin
      // Strobes are single-cycle; they are re-armed only on state entry.
      search_valid_q <= 1'b0;
      read_valid_q   <= 1'b0;
      write_valid_q  <= 1'b0;
      probe_we_q     <= 1'b0;
      tlbr_we_q      <= 1'b0;
      op_done_q      <= 1'b0;
`ifdef TLB_REFETCH_EN
      refetch_valid_q <= 1'b0;
      refetch_pc_q    <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (op_valid && !abort) begin
            kind_q  <= op_kind;
            vpn2_q  <= cp0_entryhi[31:13];
            asid_q  <= cp0_entryhi[7:0];
            index_q <= cp0_index;
`ifdef TLB_REFETCH_EN
            pc_q    <= op_pc;
`endif
            if (op_kind == KIND_NONE) begin
              // Nothing to sequence: release WB on the next cycle.
              state_q   <= DONE;
              op_done_q <= 1'b1;
            end else begin
              state_q        <= REQ;
              search_valid_q <= (op_kind == KIND_TLBP);
              read_valid_q   <= (op_kind == KIND_TLBR);
            end
          end
        end
        REQ: begin
          // Requests issued in REQ are side-effect free, so a late abort can
          // still cancel cleanly before any architectural update.
          if (abort) begin
            state_q <= IDLE;
          end else begin
            state_q       <= WAIT;
            probe_we_q    <= (kind_q == KIND_TLBP);
            tlbr_we_q     <= (kind_q == KIND_TLBR);
            write_valid_q <= (kind_q == KIND_TLBWI);
          end
        end
        WAIT: begin
          // Updates are committed in WAIT; abort is no longer honoured.
          state_q   <= DONE;
          op_done_q <= 1'b1;
`ifdef TLB_REFETCH_EN
          if (kind_q == KIND_TLBR || kind_q == KIND_TLBWI) begin
            refetch_valid_q <= 1'b1;
            refetch_pc_q    <= pc_q + 32'd4;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tlb_search_valid = search_valid_q;
  assign tlb_search_vpn2  = vpn2_q;
  assign tlb_search_asid  = asid_q;
  assign tlb_read_valid   = read_valid_q;
  assign tlb_read_index   = index_q;
  assign tlb_write_valid  = write_valid_q;
  assign tlb_write_index  = index_q;
  assign cp0_probe_we     = probe_we_q;
  assign cp0_tlbr_we      = tlbr_we_q;
  assign op_done          = op_done_q;
  assign busy             = (state_q != IDLE);

  // The probe result arrives from the TLB during WAIT, so the Index value is
  // formed from it directly while the (registered) write enable is high.
  assign cp0_probe_data = !probe_we_q     ? 32'h0000_0000 :
                          tlb_search_hit  ? {{(32-TLB_INDEX_WIDTH){1'b0}}, tlb_search_index} :
                                            32'h8000_0000;

  // EntryHi bits between VPN2 and ASID carry no meaning for the probe.
  logic unused_inputs;
`ifdef TLB_REFETCH_EN
  assign refetch_valid = refetch_valid_q;
  assign refetch_pc    = refetch_pc_q;
  assign unused_inputs = ^cp0_entryhi[12:8];
`else
  assign refetch_valid = 1'b0;
  assign refetch_pc    = 32'h0000_0000;
  assign unused_inputs = ^{cp0_entryhi[12:8], op_pc};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_op_controller
// Description : Self-checking bench for tlb_op_controller. Directed steps push
//               expected strobe events (kind, cycle, payload) to a queue; a
//               monitor pops and compares every strobe the DUT produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_op_controller;

  localparam logic [2:0] EV_SEARCH = 3'd0;
  localparam logic [2:0] EV_READ   = 3'd1;
  localparam logic [2:0] EV_WRITE  = 3'd2;
  localparam logic [2:0] EV_PROBE  = 3'd3;
  localparam logic [2:0] EV_TLBR   = 3'd4;
  localparam logic [2:0] EV_DONE   = 3'd5;
  localparam logic [2:0] EV_NONE   = 3'd7;

  typedef struct {
    logic [2:0]  k;
    int          c;
    logic [63:0] d;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_kind = 2'b00;
  logic [31:0] op_pc = 32'h0;
  logic        abort = 1'b0;
  logic [31:0] cp0_entryhi = 32'h0;
  logic [3:0]  cp0_index = 4'h0;
  logic        tlb_search_hit = 1'b0;
  logic [3:0]  tlb_search_index = 4'h0;

  logic        tlb_search_valid;
  logic [18:0] tlb_search_vpn2;
  logic [7:0]  tlb_search_asid;
  logic        tlb_read_valid;
  logic [3:0]  tlb_read_index;
  logic        tlb_write_valid;
  logic [3:0]  tlb_write_index;
  logic        cp0_probe_we;
  logic [31:0] cp0_probe_data;
  logic        cp0_tlbr_we;
  logic        op_done;
  logic        busy;
  logic        refetch_valid;
  logic [31:0] refetch_pc;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];

  logic [106:0] all_outs;
  assign all_outs = {tlb_search_valid, tlb_search_vpn2, tlb_search_asid,
                     tlb_read_valid, tlb_read_index, tlb_write_valid,
                     tlb_write_index, cp0_probe_we, cp0_probe_data,
                     cp0_tlbr_we, op_done, busy, refetch_valid, refetch_pc};

  tlb_op_controller #(.TLB_INDEX_WIDTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .op_valid         (op_valid),
    .op_kind          (op_kind),
    .op_pc            (op_pc),
    .abort            (abort),
    .cp0_entryhi      (cp0_entryhi),
    .cp0_index        (cp0_index),
    .tlb_search_valid (tlb_search_valid),
    .tlb_search_vpn2  (tlb_search_vpn2),
    .tlb_search_asid  (tlb_search_asid),
    .tlb_search_hit   (tlb_search_hit),
    .tlb_search_index (tlb_search_index),
    .tlb_read_valid   (tlb_read_valid),
    .tlb_read_index   (tlb_read_index),
    .tlb_write_valid  (tlb_write_valid),
    .tlb_write_index  (tlb_write_index),
    .cp0_probe_we     (cp0_probe_we),
    .cp0_probe_data   (cp0_probe_data),
    .cp0_tlbr_we      (cp0_tlbr_we),
    .op_done          (op_done),
    .busy             (busy),
    .refetch_valid    (refetch_valid),
    .refetch_pc       (refetch_pc)
  );

  always #5 clock = ~clock;

  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input int c, input logic [63:0] d);
    sb.push_back('{k: k, c: c, d: d});
  endtask

  // Compare one observed strobe against the oldest expectation.
  task automatic observe(input logic [2:0] k, input logic [63:0] d);
    ev_t e;
    e = '{k: EV_NONE, c: -1, d: 64'h0};
    if (sb.size() != 0) e = sb.pop_front();
    checks++;
    assert ({k, cyc, d} === {e.k, e.c, e.d}) else begin
      errors++;
      $error("FAIL ev_%0d: observed k=%0d cyc=%0d d=%0h expected k=%0d cyc=%0d d=%0h",
             k, k, cyc, d, e.k, e.c, e.d);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the scoreboard.
  always @(negedge clock) begin
    if (tlb_search_valid) observe(EV_SEARCH, {37'b0, tlb_search_vpn2, tlb_search_asid});
    if (tlb_read_valid)   observe(EV_READ,   {60'b0, tlb_read_index});
    if (tlb_write_valid)  observe(EV_WRITE,  {60'b0, tlb_write_index});
    if (cp0_probe_we)     observe(EV_PROBE,  {32'b0, cp0_probe_data});
    if (cp0_tlbr_we)      observe(EV_TLBR,   64'h0);
    if (op_done || refetch_valid) observe(EV_DONE, {31'b0, refetch_valid, refetch_pc});
  end

  // Present an op and queue the strobes expected through phase 'upto'
  // (1 = REQ, 2 = WAIT, 3 = DONE).
  task automatic issue(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] ehi,
                       input logic [3:0] idx, input logic hit, input logic [3:0] sidx,
                       input int upto);
    int          t;
    logic [31:0] npc;
    logic        rf;
    op_kind = k; op_pc = pc; cp0_entryhi = ehi; cp0_index = idx;
    tlb_search_hit = hit; tlb_search_index = sidx;
    op_valid = 1'b1;
    t   = cyc;
    npc = pc + 32'd4;
`ifdef TLB_REFETCH_EN
    rf = (k == 2'b10) || (k == 2'b11);
`else
    rf = 1'b0;
`endif
    case (k)
      2'b00: if (upto >= 1) push(EV_DONE, t + 1, 64'h0);
      2'b01: begin
        if (upto >= 1) push(EV_SEARCH, t + 1, {37'b0, ehi[31:13], ehi[7:0]});
        if (upto >= 2) push(EV_PROBE, t + 2, hit ? {60'b0, sidx} : 64'h8000_0000);
        if (upto >= 3) push(EV_DONE, t + 3, 64'h0);
      end
      2'b10: begin
        if (upto >= 1) push(EV_READ, t + 1, {60'b0, idx});
        if (upto >= 2) push(EV_TLBR, t + 2, 64'h0);
        if (upto >= 3) push(EV_DONE, t + 3, {31'b0, rf, rf ? npc : 32'h0});
      end
      default: begin
        if (upto >= 2) push(EV_WRITE, t + 2, {60'b0, idx});
        if (upto >= 3) push(EV_DONE, t + 3, {31'b0, rf, rf ? npc : 32'h0});
      end
    endcase
  endtask

  // Hold the op until op_done (bounded), scrambling the sampled-at-accept
  // inputs meanwhile; optionally drop op_valid early.
  task automatic finish_op(input string tag, input bit drop);
    int n;
    step();
    chk({tag, "_busy"}, busy, 1);
    op_kind = ~op_kind; op_pc = $urandom; cp0_entryhi = $urandom; cp0_index = 4'($urandom);
    if (drop) op_valid = 1'b0;
    n = 0;
    while (!op_done && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_done"}, op_done, 1);
    step();
    op_valid = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    // Reset state
    step(); step(); step();
    chk("reset_outs", all_outs, 0);
    reset = 1'b0;
    step();
    chk("post_reset_outs", all_outs, 0);

    // TLBP hit, then back-to-back TLBP miss
    issue(2'b01, 32'h8000_0010, 32'h1234_6005, 4'h0, 1'b1, 4'h5, 3);
    finish_op("tlbp_hit", 1'b0);
    issue(2'b01, 32'h8000_0014, 32'hABCD_E0FF, 4'h2, 1'b0, 4'hA, 3);
    finish_op("tlbp_miss", 1'b0);

    // TLBWI index 9
    issue(2'b11, 32'hBFC0_0100, 32'h0000_2001, 4'h9, 1'b0, 4'h0, 3);
    finish_op("tlbwi", 1'b0);

    // TLBR index 3 with wrapping PC
    issue(2'b10, 32'hFFFF_FFFC, 32'h0000_0000, 4'h3, 1'b0, 4'h0, 3);
    finish_op("tlbr_wrap", 1'b0);

    // Kind 00 completes in one cycle
    issue(2'b00, 32'h0000_1000, 32'h0, 4'h7, 1'b0, 4'h0, 3);
    finish_op("kind_none", 1'b0);

    // TLBR with op_valid dropped in REQ still completes
    issue(2'b10, 32'h0040_0000, 32'h0, 4'hC, 1'b0, 4'h0, 3);
    finish_op("tlbr_drop", 1'b1);

    // abort together with op_valid in IDLE: not accepted
    op_kind = 2'b01; cp0_entryhi = 32'h5555_5555; op_valid = 1'b1; abort = 1'b1;
    step(); step();
    chk("abort_idle_busy", busy, 0);
    op_valid = 1'b0; abort = 1'b0;
    step();

    // abort in REQ of a TLBWI: no write, no op_done
    issue(2'b11, 32'h0000_2000, 32'h0, 4'h6, 1'b0, 4'h0, 1);
    step();
    chk("abort_req_busy", busy, 1);
    abort = 1'b1;
    step();
    chk("abort_req_idle", {busy, op_done}, 0);
    op_valid = 1'b0; abort = 1'b0;
    step(); step();

    // abort in WAIT of a TLBR: ignored
    issue(2'b10, 32'h0000_3000, 32'h0, 4'hE, 1'b0, 4'h0, 3);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_wait_done", op_done, 1);
    step();
    op_valid = 1'b0;
    step();

    // reset in WAIT of a TLBP, then a fresh TLBP
    issue(2'b01, 32'h0000_4000, 32'hFFFF_E0AA, 4'h1, 1'b1, 4'hB, 2);
    step(); step();
    reset = 1'b1;
    op_valid = 1'b0;
    step();
    chk("reset_wait_outs", all_outs, 0);
    reset = 1'b0;
    step();
    issue(2'b01, 32'h0000_5000, 32'h0246_8A11, 4'h0, 1'b1, 4'hF, 3);
    finish_op("tlbp_after_reset", 1'b0);

    step(); step(); step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
